// File: rtl/seq_alu.sv
// seq_alu: clocked EX-stage ALU with a start/busy/done handshake.
// Single-cycle ops finish through EXEC. Unsigned multiply (shift-add) and
// unsigned divide (restoring) iterate one bit per cycle in MUL/DIV.
// All result flags are registered when the FSM enters DONE and then held.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUCtrl,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] ALUResultHi,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int SH_W  = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;

   state_t state, state_next;

   logic [3:0]         op;
   logic [WIDTH-1:0]   op_a, op_b;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   count;

   logic [WIDTH-1:0]   alu_res, alu_hi, sum, diff;
   logic               alu_ovf, alu_dbz;
   logic [SH_W-1:0]    shamt;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_sh, div_diff;
   logic [2*WIDTH-1:0] div_next;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; starts are only honoured in IDLE, and a zero divisor
   // is routed through the single-cycle path.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (ALUCtrl == OP_MULU)                       state_next = MUL;
               else if (ALUCtrl == OP_DIVU && inB != '0)     state_next = DIV;
               else                                          state_next = EXEC;
            end
         end
         EXEC:    state_next = DONE;
         MUL,
         DIV:     if (count == CNT_W'(1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Single-cycle result, also covering the divide-by-zero case.
   always_comb begin
      sum     = op_a + op_b;
      diff    = op_a - op_b;
      shamt   = op_b[SH_W-1:0];
      alu_res = '0;
      alu_hi  = '0;
      alu_ovf = 1'b0;
      alu_dbz = 1'b0;
      case (op)
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_NOR: alu_res = ~(op_a | op_b);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLL: alu_res = op_a << shamt;
         OP_SRL: alu_res = op_a >> shamt;
         OP_SRA: alu_res = $signed(op_a) >>> shamt;
         OP_DIVU: begin
            alu_res = '1;
            alu_hi  = op_a;
            alu_dbz = 1'b1;
         end
         default: alu_res = '0;
      endcase
   end

   // One iteration of shift-add multiply and restoring divide on the accumulator.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_sh - {1'b0, op_b};
      if (div_diff[WIDTH])
         div_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // Operand capture, iteration and result registers; outputs change only on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         op          <= '0;
         op_a        <= '0;
         op_b        <= '0;
         acc         <= '0;
         count       <= '0;
         ALUResult   <= '0;
         ALUResultHi <= '0;
         zero        <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op    <= ALUCtrl;
                  op_a  <= inA;
                  op_b  <= inB;
                  count <= CNT_W'(WIDTH);
                  acc   <= (ALUCtrl == OP_DIVU) ? {{WIDTH{1'b0}}, inA} : {{WIDTH{1'b0}}, inB};
               end
            end
            EXEC: begin
               ALUResult   <= alu_res;
               ALUResultHi <= alu_hi;
               zero        <= (alu_res == '0);
               overflow    <= alu_ovf;
               div_by_zero <= alu_dbz;
            end
            MUL: begin
               acc   <= mul_next;
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  ALUResult   <= mul_next[WIDTH-1:0];
                  ALUResultHi <= mul_next[2*WIDTH-1:WIDTH];
                  zero        <= (mul_next[WIDTH-1:0] == '0);
                  overflow    <= 1'b0;
                  div_by_zero <= 1'b0;
               end
            end
            DIV: begin
               acc   <= div_next;
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  ALUResult   <= div_next[WIDTH-1:0];
                  ALUResultHi <= div_next[2*WIDTH-1:WIDTH];
                  zero        <= (div_next[WIDTH-1:0] == '0);
                  overflow    <= 1'b0;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
